// File: rtl/bspi_target.sv
// Boot-SPI target: oversamples SPI pins in the clk domain and turns framed
// transactions into word writes/reads on the boot-memory port.
module bspi_target #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              io_bcf,
    input  logic              io_scs,
    input  logic              io_sck,
    input  logic              io_sdi,
    output logic              io_sdo,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StHdr    = 3'd1;
    localparam logic [2:0] StWdata  = 3'd2;
    localparam logic [2:0] StRfetch = 3'd3;
    localparam logic [2:0] StRshift = 3'd4;
    localparam logic [2:0] StIgnore = 3'd5;

    localparam logic [ADDR_W-1:0] AddrOne = 1;

    logic scs_s1_q, scs_s2_q, scs_prev_q;
    logic sck_s1_q, sck_s2_q, sck_prev_q, rise_q;
    logic sdi_s1_q, sdi_s2_q;
    logic [1:0] arm_cnt_q;
    logic cs_ok_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scs_s1_q   <= 1'b1;
            scs_s2_q   <= 1'b1;
            scs_prev_q <= 1'b1;
            sck_s1_q   <= 1'b0;
            sck_s2_q   <= 1'b0;
            sck_prev_q <= 1'b0;
            rise_q     <= 1'b0;
            sdi_s1_q   <= 1'b0;
            sdi_s2_q   <= 1'b0;
            arm_cnt_q  <= 2'd0;
            cs_ok_q    <= 1'b0;
        end else begin
            scs_s1_q   <= io_scs;
            scs_s2_q   <= scs_s1_q;
            scs_prev_q <= scs_s2_q;
            sck_s1_q   <= io_sck;
            sck_s2_q   <= sck_s1_q;
            sck_prev_q <= sck_s2_q;
            rise_q     <= sck_s2_q & ~sck_prev_q;
            sdi_s1_q   <= io_sdi;
            sdi_s2_q   <= sdi_s1_q;
            // Only accept a new frame once CS has really been seen high after reset,
            // so a frame already in flight at reset release is ignored.
            if (arm_cnt_q != 2'd3) begin
                arm_cnt_q <= arm_cnt_q + 2'd1;
            end else if (scs_s2_q) begin
                cs_ok_q <= 1'b1;
            end
        end
    end

    logic cs_fall, cs_rise, fall_now;
    assign cs_fall  = scs_prev_q & ~scs_s2_q;
    assign cs_rise  = ~scs_prev_q & scs_s2_q;
    // Unregistered falling detect keeps io_sdo updates 3 clk after the pin edge.
    assign fall_now = sck_prev_q & ~sck_s2_q;

    logic [2:0]        state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_q, rx_d, rx_next;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              we_q, we_d, re_q, re_d;
    logic              fetch_q, fetch_d;
    logic              sdo_q, sdo_d;

    assign rx_next = {rx_q[DATA_W-2:0], sdi_s2_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        fetch_d     = fetch_q;
        sdo_d       = sdo_q;

        case (state_q)
            StIdle: begin
                if (io_bcf && cs_ok_q && cs_fall) begin
                    state_d = StHdr;
                    cnt_d   = 6'd0;
                    rx_d    = '0;
                end
            end
            StHdr: begin
                if (rise_q) begin
                    rx_d  = rx_next;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd15) begin
                        cnt_d  = 6'd0;
                        addr_d = rx_next[ADDR_W-1:0];
                        if (rx_next[13:ADDR_W] != '0) begin
                            state_d = StIgnore;
                        end else if (rx_next[15:14] == 2'b10) begin
                            state_d = StWdata;
                        end else if (rx_next[15:14] == 2'b11) begin
                            state_d    = StRfetch;
                            re_d       = 1'b1;
                            mem_addr_d = rx_next[ADDR_W-1:0];
                            fetch_d    = 1'b0;
                        end else begin
                            state_d = StIgnore;
                        end
                    end
                end
            end
            StWdata: begin
                if (rise_q) begin
                    rx_d  = rx_next;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        cnt_d       = 6'd0;
                        we_d        = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = rx_next;
                        addr_d      = addr_q + AddrOne;
                    end
                end
            end
            StRfetch: begin
                // mem_re is high this cycle; read data lands on the next one.
                if (!fetch_q) begin
                    fetch_d = 1'b1;
                end else begin
                    tx_d    = mem_rdata;
                    fetch_d = 1'b0;
                    cnt_d   = 6'd0;
                    state_d = StRshift;
                end
            end
            StRshift: begin
                if (fall_now && cnt_q != 6'd32) begin
                    sdo_d = tx_q[DATA_W-1];
                    tx_d  = {tx_q[DATA_W-2:0], 1'b0};
                    cnt_d = cnt_q + 6'd1;
                end else if (rise_q && cnt_q == 6'd32) begin
                    // Master has sampled the last bit; prefetch the next word.
                    addr_d     = addr_q + AddrOne;
                    mem_addr_d = addr_q + AddrOne;
                    re_d       = 1'b1;
                    fetch_d    = 1'b0;
                    cnt_d      = 6'd0;
                    state_d    = StRfetch;
                end
            end
            StIgnore: begin
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && (cs_rise || !io_bcf)) begin
            state_d = StIdle;
            cnt_d   = 6'd0;
            we_d    = 1'b0;
            re_d    = 1'b0;
            fetch_d = 1'b0;
        end
        if (state_d != StRshift) begin
            sdo_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 6'd0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            fetch_q     <= 1'b0;
            sdo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            fetch_q     <= fetch_d;
            sdo_q       <= sdo_d;
        end
    end

    assign io_sdo    = sdo_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = we_q;
    assign mem_re    = re_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_bspi_target.sv
// Scoreboard bench for bspi_target: an SPI master task feeds frames, a frame-level
// model predicts memory strobes and read words, and a monitor checks the DUT.
module tb_bspi_target;

    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_bcf, io_scs, io_sck, io_sdi, io_sdo;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_we, mem_re, busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [10:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    logic [10:0] exp_ra[$];
    logic [31:0] exp_rw[$];
    logic [31:0] got_rw[$];

    logic [31:0] ram[2048];
    logic        ram_valid[2048];
    logic [31:0] ref_mem[2048];

    bspi_target #(.ADDR_W(11), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .io_bcf    (io_bcf),
        .io_scs    (io_scs),
        .io_sck    (io_sck),
        .io_sdi    (io_sdi),
        .io_sdo    (io_sdo),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [10:0] a);
        return ({21'h0, a} * 32'h9E3779B1) ^ 32'hC0FFEE11;
    endfunction

    // Boot memory: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]       <= mem_wdata;
            ram_valid[mem_addr] <= 1'b1;
        end
        if (mem_re) mem_rdata <= (ram_valid[mem_addr] === 1'b1) ? ram[mem_addr]
                                                               : init_val(mem_addr);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every strobe and every captured read word against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (mem_we && mem_re) chk("we_re_exclusive", 1, 0);
                if (mem_we) begin
                    if (exp_wa.size() == 0) chk("unexpected_we", 1, 0);
                    else begin
                        chk("wr_addr", mem_addr, exp_wa.pop_front());
                        chk("wr_data", mem_wdata, exp_wd.pop_front());
                    end
                end
                if (mem_re) begin
                    if (exp_ra.size() == 0) chk("unexpected_re", 1, 0);
                    else chk("rd_addr", mem_addr, exp_ra.pop_front());
                end
            end
            if (got_rw.size() > 0) begin
                if (exp_rw.size() == 0) chk("unexpected_rd_word", 1, 0);
                else chk("rd_sdo_word", got_rw.pop_front(), exp_rw.pop_front());
            end
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_sdo", io_sdo, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_re", mem_re, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
    endtask

    // cut > 0: stop after that many bits (abort), or with do_rst pulse rst there and
    // send the rest of the frame anyway.
    task automatic send_frame(input logic [15:0] hdr, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2,
                              input int nwords, input int cut, input bit do_rst,
                              input bit bcf);
        logic [111:0] frame;
        logic [31:0]  w[3];
        logic [31:0]  cap;
        logic [10:0]  a, wa;
        logic         sdo_seen;
        int           total, nsend, nfull;
        bit           is_rd;
        frame = {hdr, w0, w1, w2};
        w[0] = w0; w[1] = w1; w[2] = w2;
        total = 16 + 32 * nwords;
        nsend = (cut > 0 && !do_rst) ? cut : total;
        nfull = (cut > 0) ? ((cut > 16) ? (cut - 16) / 32 : 0) : nwords;
        a = hdr[10:0];
        is_rd = 1'b0;
        if (bcf && !do_rst && hdr[13:11] == 3'b000) begin
            if (hdr[15:14] == 2'b10) begin
                for (int i = 0; i < nfull; i++) begin
                    wa = a + i[10:0];
                    exp_wa.push_back(wa);
                    exp_wd.push_back(w[i]);
                    ref_mem[wa] = w[i];
                end
            end else if (hdr[15:14] == 2'b11) begin
                is_rd = 1'b1;
                for (int i = 0; i <= nwords; i++) exp_ra.push_back(a + i[10:0]);
                for (int i = 0; i < nwords; i++) exp_rw.push_back(ref_mem[a + i[10:0]]);
            end
        end
        io_bcf = bcf;
        io_scs = 1'b0;
        cap = '0;
        sdo_seen = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nsend; i++) begin
            io_sdi = frame[111 - i];
            wait_clk(HALF);
            io_sck = 1'b1;
            if (i >= 16) begin
                cap = {cap[30:0], io_sdo};
                sdo_seen = sdo_seen | io_sdo;
                if (is_rd && (i - 16) % 32 == 31) got_rw.push_back(cap);
            end
            if (do_rst && i == cut - 1) begin
                rst = 1'b1;
                #1;
                chk_reset_outputs();
                wait_clk(3);
                rst = 1'b0;
            end
            wait_clk(HALF);
            io_sck = 1'b0;
        end
        wait_clk(HALF);
        chk("busy_in_frame", busy, bcf && !do_rst);
        if (!is_rd) chk("sdo_quiet", sdo_seen, 0);
        io_scs = 1'b1;
        io_sdi = 1'b0;
        wait_clk(8);
        chk("busy_after_cs", busy, 0);
    endtask

    initial begin
        logic [1:0]  cmd;
        logic [2:0]  rsv;
        logic [15:0] hdr;
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i[10:0]);
        rst = 1'b1;
        io_bcf = 1'b0; io_scs = 1'b1; io_sck = 1'b0; io_sdi = 1'b0;
        wait_clk(4);
        chk_reset_outputs();
        rst = 1'b0;
        wait_clk(8);
        io_bcf = 1'b1;

        send_frame(16'h8000, 32'h12C00093, 32'h0, 32'h0, 1, 0, 1'b0, 1'b1);
        send_frame(16'h87FF, 32'hAAAA5555, 32'h0000000F, 32'h0, 2, 0, 1'b0, 1'b1);
        send_frame(16'h8005, 32'hDEADBEEF, 32'h0, 32'h0, 1, 0, 1'b0, 1'b1);
        send_frame(16'hC005, 32'h0, 32'h0, 32'h0, 1, 0, 1'b0, 1'b1);
        send_frame(16'h8010, $urandom, 32'h0, 32'h0, 1, 36, 1'b0, 1'b1);
        send_frame(16'h8001, 32'h00000001, 32'h0, 32'h0, 1, 0, 1'b0, 1'b1);
        send_frame(16'h8003, 32'h13572468, 32'h0, 32'h0, 1, 0, 1'b0, 1'b0);
        send_frame(16'h4003, 32'h11223344, 32'h0, 32'h0, 1, 0, 1'b0, 1'b1);
        send_frame(16'h8020, 32'hCAFEF00D, 32'h01020304, 32'h0, 2, 40, 1'b1, 1'b1);
        send_frame(16'h8002, 32'h00000005, 32'h0, 32'h0, 1, 0, 1'b0, 1'b1);
        send_frame(16'hC7FF, 32'h0, 32'h0, 32'h0, 2, 0, 1'b0, 1'b1);

        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 5))
                0, 1:    cmd = 2'b10;
                2, 3:    cmd = 2'b11;
                4:       cmd = 2'b01;
                default: cmd = 2'b00;
            endcase
            rsv = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'b000;
            hdr = {cmd, rsv, 11'($urandom)};
            send_frame(hdr, $urandom, $urandom, $urandom, $urandom_range(1, 3), 0, 1'b0,
                       $urandom_range(0, 5) != 0);
        end

        wait_clk(30);
        chk("writes_left", exp_wa.size(), 0);
        chk("reads_left", exp_ra.size(), 0);
        chk("rd_words_left", exp_rw.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bspi_target.md
# bspi_target

Boot-SPI target (responder) that decodes framed SPI transactions from an external boot/config master and turns them into word writes and reads on the SoC boot-memory port. It sits between the `io_scs`/`io_sck`/`io_sdi`/`io_sdo`/`io_bcf` pads and the instruction/data memory arbitration logic of `rv151_soc`. It oversamples the SPI pins in the `clk` domain; no logic is clocked by `io_sck`.

## Interface
- `ADDR_W`, 11: word-address width, taken from header bits [10:0].
- `DATA_W`, 32: data word width.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `io_bcf`  in  1  boot-config enable; frames are decoded only while high.
- `io_scs`  in  1  SPI chip select, active-low, asynchronous to `clk`.
- `io_sck`  in  1  SPI clock, idle level don't-care, asynchronous.
- `io_sdi`  in  1  SPI data in, MSB first.
- `io_sdo`  out  1  SPI data out, MSB first.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  DATA_W  write data.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_re`  out  1  one-cycle read strobe.
- `mem_rdata`  in  DATA_W  read data, valid exactly 1 `clk` after `mem_re`.
- `busy`  out  1  high while a frame is active (CS low and `io_bcf` high).

## Operation
- Synchronize `io_scs`, `io_sck`, and `io_sdi` through 2-flop synchronizers.
- Detect rising and falling edges of `io_sck` on the synchronized value.
- `io_sdi` is sampled on each detected rising edge.
- Frame format: a 16-bit header `{cmd[1:0], 3'b000, addr[10:0]}`, followed by 32-bit data words, all MSB first.
- `cmd` 2'h2 is WRITE and 2'h3 is READ. Any other value, or nonzero reserved bits, sends the FSM to IGNORE.
- FSM states are IDLE, HDR, WDATA, RFETCH, RSHIFT, and IGNORE.
- IDLE → HDR: synchronized CS falls while `io_bcf` = 1. The bit counter clears to 0.
- HDR: shift in 16 bits. On the 16th rising edge, latch `addr` and decode `cmd`. The next state is WDATA, RFETCH, or IGNORE.
- WDATA: shift in 32 bits. On the 32nd rising edge:
  - the next cycle drives `mem_addr` = addr and `mem_wdata` = the shifted word, with `mem_we` = 1 for one cycle;
  - addr then increments by 1 and wraps from 0x7FF to 0x000;
  - the bit counter clears and the FSM stays in WDATA for a burst.
- RFETCH: pulse `mem_re` for one cycle with `mem_addr` = addr. On the following cycle, load `mem_rdata` into the TX shift register, then go to RSHIFT.
- RSHIFT: on each falling edge, `io_sdo` takes the next TX bit, starting from bit 31. After the 32nd bit has been presented, addr increments and the FSM returns to RFETCH for a burst read.
- IGNORE: all SPI edges are ignored until CS rises.
- CS rising (synchronized), in any state → IDLE:
  - partial words are discarded and no strobe is issued;
  - a write strobe already scheduled for the current cycle still completes.
- `io_bcf` falling in any state → IDLE on the next cycle, with the same discard rule as CS rising.
- `mem_we` and `mem_re` are never high in the same cycle.

## Timing
- Constraint: the SPI high and low phases must each be at least 4 `clk` periods. At faster SCK, behaviour is undefined.
- Rising edge detection occurs 3 `clk` after the pin edge (2 synchronizer flops plus the edge register).
- Write: `mem_we` rises 1 `clk` after the detected 32nd data rising edge, which is 4 `clk` after the pin edge.
- Read: `mem_re` is asserted 1 `clk` after the detected 16th header rising edge. The TX register loads 1 `clk` later. `io_sdo` bit 31 is valid from 3 `clk` after the next pin falling edge.
- Read latency under the minimum SCK phase: TX data is ready before the first falling edge is detected.
- Reset values:
  - FSM = IDLE;
  - `io_sdo` = 0, `mem_we` = 0, `mem_re` = 0, `busy` = 0;
  - `mem_addr` = 0, `mem_wdata` = 0;
  - shift registers and counters = 0;
  - synchronizer flops are preset to CS = 1, SCK = 0, SDI = 0.
- `io_sdo` is 0 whenever the FSM is not in RSHIFT.
- `rst` asserted mid-frame: the FSM goes to IDLE immediately. After `rst` deasserts, the remainder of a frame still in progress is ignored until CS rises, because the IDLE → HDR transition requires a CS falling edge.

## Test plan
- **Single write.** Drive `io_bcf` = 1, SCK phase 4 `clk`, header 0x8000, data 0x12C00093.
  - Required: exactly one `mem_we` pulse with `mem_addr` = 0x000 and `mem_wdata` = 0x12C00093.
- **Burst write with wrap.** Header 0x87FF, two data words 0xAAAA5555 and 0x0000000F.
  - Required: writes to 0x7FF with 0xAAAA5555, then 0x000 with 0x0000000F.
- **Read.** Header 0xC005, with the memory model returning 0xDEADBEEF.
  - Required: one `mem_re` at address 0x005, and the 32 `io_sdo` bits sampled on SCK rising edges equal 0xDEADBEEF.
- **Abort.** Raise CS after 20 of the 32 data bits of a write.
  - Required: no `mem_we`. A following full frame, header 0x8001 with data 0x1, writes correctly.
- **Gating and bad command.**
  - Frame with `io_bcf` = 0: no strobes.
  - Header 0x4003 (bad command): IGNORE state, no strobes; `busy` stays high until CS rises.
- **Async reset mid-frame.** Assert `rst` on the 40th bit of a write.
  - Required: all outputs reach their reset values immediately and no `mem_we` is issued.
  - After CS toggles, a new frame with header 0x8002 and data 0x5 writes correctly.
